pc_sequencer: RTL and testbench

- Parametrised program-counter sequencer for the next-generation core.
- Holds the PC and selects the next PC: increment, absolute jump, PC-relative conditional branch, call or return.
- Contains a return-address stack of configurable depth with overflow/underflow detection and a halt state machine.
- Sits between instruction memory (drives the fetch address) and the controller (receives pc_op and cond).

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/ras_stack.sv | 44 ++++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: op encodings and FSM states.
package pc_seq_pkg;

    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        OP_INC  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BR   = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_RETI = 3'd5
    } pc_op_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO: occupancy counter with async reset, storage left unreset.
module ras_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;

    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign top   = r_mem[AW'(r_count - CW'(1))];

    // Callers gate push/pop with full/empty; the guards here only keep the pointer sane.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (push && !full) begin
            r_count <= r_count + CW'(1);
        end else if (pop && !empty) begin
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[AW'(r_count)] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC mux, return-address stack and RUN/HALT FSM.
// Optional interrupt entry/exit is enabled by defining PC_SEQ_IRQ_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               PC_W      = 12,
    parameter int               OFF_W     = 8,
    parameter int               DEPTH     = 8,
    parameter logic [PC_W-1:0]  RESET_VEC = '0,
    parameter logic [PC_W-1:0]  IRQ_VEC   = PC_W'(12'h010),
    localparam int              DW        = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [PC_OP_W-1:0] pc_op,
    input  logic               cond,
    input  logic [PC_W-1:0]    target,
    input  logic [OFF_W-1:0]   offset,
`ifdef PC_SEQ_IRQ_EN
    input  logic               irq,
    output logic               in_isr,
`endif
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus1,
    output logic [DW-1:0]      depth,
    output logic               halted,
    output logic               ovf,
    output logic               unf
);

    seq_state_t       r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_ovf;
    logic             r_unf;

    logic             w_run;
    logic             w_irq_take;
    logic             w_is_call;
    logic             w_is_ret;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [PC_W-1:0]  w_top;
    logic [PC_W-1:0]  w_pc_plus1;
    logic [PC_W-1:0]  w_off_sx;
    logic [PC_W-1:0]  w_pc_nxt;
    pc_op_t           w_op;

    assign w_op       = pc_op_t'(pc_op);
    assign w_run      = (r_state == RUN) && !stall;
    assign w_pc_plus1 = r_pc + PC_W'(1);
    assign w_off_sx   = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};

`ifdef PC_SEQ_IRQ_EN
    logic r_in_isr;
    assign w_irq_take = w_run && irq && !r_in_isr;
    assign in_isr     = r_in_isr;
`else
    assign w_irq_take = 1'b0;
`endif

    // An accepted interrupt overrides whatever op the controller presents.
    assign w_is_call = w_run && !w_irq_take && (w_op == OP_CALL);
    assign w_is_ret  = w_run && !w_irq_take && ((w_op == OP_RET) || (w_op == OP_RETI));
    assign w_push    = (w_is_call || w_irq_take) && !w_full;
    assign w_pop     = w_is_ret && !w_empty;

    ras_stack #(
        .WIDTH (PC_W),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_irq_take ? r_pc : w_pc_plus1),
        .top   (w_top),
        .count (depth),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_irq_take) begin
            if (!w_full) w_pc_nxt = IRQ_VEC;
        end else if (w_run) begin
            case (w_op)
                OP_JMP:           w_pc_nxt = target;
                OP_BR:            w_pc_nxt = cond ? (w_pc_plus1 + w_off_sx) : w_pc_plus1;
                OP_CALL:          if (!w_full)  w_pc_nxt = target;
                OP_RET, OP_RETI:  if (!w_empty) w_pc_nxt = w_top;
                default:          w_pc_nxt = w_pc_plus1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_pc    <= RESET_VEC;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if ((w_is_call || w_irq_take) && w_full) begin
                r_ovf   <= 1'b1;
                r_state <= HALT;
            end
            if (w_is_ret && w_empty) begin
                r_unf   <= 1'b1;
                r_state <= HALT;
            end
        end
    end

`ifdef PC_SEQ_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_isr <= 1'b0;
        end else if (w_irq_take && !w_full) begin
            r_in_isr <= 1'b1;
        end else if (w_pop && (w_op == OP_RETI)) begin
            r_in_isr <= 1'b0;
        end
    end
`endif

    assign pc       = r_pc;
    assign pc_plus1 = w_pc_plus1;
    assign halted   = (r_state == HALT);
    assign ovf      = r_ovf;
    assign unf      = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default build; IRQ steps when PC_SEQ_IRQ_EN is defined).
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  pc_op;
    logic        cond;
    logic [11:0] target;
    logic [7:0]  offset;
    logic [11:0] pc;
    logic [11:0] pc_plus1;
    logic [3:0]  depth;
    logic        halted;
    logic        ovf;
    logic        unf;
`ifdef PC_SEQ_IRQ_EN
    logic        irq;
    logic        in_isr;
`endif

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .pc_op    (pc_op),
        .cond     (cond),
        .target   (target),
        .offset   (offset),
`ifdef PC_SEQ_IRQ_EN
        .irq      (irq),
        .in_isr   (in_isr),
`endif
        .pc       (pc),
        .pc_plus1 (pc_plus1),
        .depth    (depth),
        .halted   (halted),
        .ovf      (ovf),
        .unf      (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [11:0] e_pc, input logic [3:0] e_d,
                             input logic e_h, input logic e_o, input logic e_u);
        check({tag, ".pc"},     16'(pc),     16'(e_pc));
        check({tag, ".depth"},  16'(depth),  16'(e_d));
        check({tag, ".halted"}, 16'(halted), 16'(e_h));
        check({tag, ".ovf"},    16'(ovf),    16'(e_o));
        check({tag, ".unf"},    16'(unf),    16'(e_u));
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic step(input logic [2:0] op, input logic [11:0] tgt, input logic [7:0] off,
                        input logic c, input logic s);
        pc_op  = op;
        target = tgt;
        offset = off;
        cond   = c;
        stall  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; pc_op = 3'd0; cond = 1'b0; target = '0; offset = '0;
`ifdef PC_SEQ_IRQ_EN
        irq = 1'b0;
`endif
        #2;
        chk_state("reset0", 12'h000, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // Asynchronous reset mid-run with pc=0x123, depth=3
        step(OP_CALL, 12'h050, 8'h00, 1'b0, 1'b0);
        step(OP_CALL, 12'h060, 8'h00, 1'b0, 1'b0);
        step(OP_CALL, 12'h070, 8'h00, 1'b0, 1'b0);
        step(OP_JMP,  12'h123, 8'h00, 1'b0, 1'b0);
        chk_state("prerst", 12'h123, 4'd3, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk_state("asyncrst", 12'h000, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // Branches and wrap-around
        step(OP_JMP, 12'h010, 8'h00, 1'b0, 1'b0);
        step(OP_BR,  12'h000, 8'hF0, 1'b1, 1'b0);
        check("br_taken_neg", 16'(pc), 16'h001);
        step(OP_JMP, 12'h010, 8'h00, 1'b0, 1'b0);
        step(OP_BR,  12'h000, 8'hF0, 1'b0, 1'b0);
        check("br_not_taken", 16'(pc), 16'h011);
        step(OP_JMP, 12'hFFF, 8'h00, 1'b0, 1'b0);
        check("pc_plus1_wrap", 16'(pc_plus1), 16'h000);
        step(OP_INC, 12'h000, 8'h00, 1'b0, 1'b0);
        check("inc_wrap", 16'(pc), 16'h000);
        step(OP_JMP, 12'hFFE, 8'h00, 1'b0, 1'b0);
        step(OP_BR,  12'h000, 8'h05, 1'b1, 1'b0);
        check("br_fwd_wrap", 16'(pc), 16'h004);
        step(3'd6, 12'h777, 8'h00, 1'b1, 1'b0);
        check("reserved6_inc", 16'(pc), 16'h005);
        step(3'd7, 12'h777, 8'h00, 1'b1, 1'b0);
        check("reserved7_inc", 16'(pc), 16'h006);

        // Call/return nesting
        step(OP_JMP,  12'h020, 8'h00, 1'b0, 1'b0);
        step(OP_CALL, 12'h100, 8'h00, 1'b0, 1'b0);
        chk_state("call1", 12'h100, 4'd1, 1'b0, 1'b0, 1'b0);
        step(OP_CALL, 12'h200, 8'h00, 1'b0, 1'b0);
        chk_state("call2", 12'h200, 4'd2, 1'b0, 1'b0, 1'b0);
        step(OP_RET,  12'h000, 8'h00, 1'b0, 1'b0);
        chk_state("ret1", 12'h101, 4'd1, 1'b0, 1'b0, 1'b0);
        step(OP_RETI, 12'h000, 8'h00, 1'b0, 1'b0);
        chk_state("ret2", 12'h021, 4'd0, 1'b0, 1'b0, 1'b0);

        // Stall holds everything, including a JMP
        step(OP_JMP, 12'h3AA, 8'h00, 1'b0, 1'b1);
        check("stall_hold", 16'(pc), 16'h021);
        step(OP_JMP, 12'h3AA, 8'h00, 1'b0, 1'b0);
        check("stall_release", 16'(pc), 16'h3AA);

        // Return address pushed from the all-ones PC wraps to 0
        step(OP_JMP,  12'hFFF, 8'h00, 1'b0, 1'b0);
        step(OP_CALL, 12'h123, 8'h00, 1'b0, 1'b0);
        step(OP_RET,  12'h000, 8'h00, 1'b0, 1'b0);
        chk_state("ret_wrap", 12'h000, 4'd0, 1'b0, 1'b0, 1'b0);

        // Overflow: 8 CALLs fill the stack, the 9th halts
        for (int i = 0; i < 8; i++) step(OP_CALL, 12'(12'h300 + i), 8'h00, 1'b0, 1'b0);
        chk_state("full", 12'h307, 4'd8, 1'b0, 1'b0, 1'b0);
        step(OP_CALL, 12'h400, 8'h00, 1'b0, 1'b0);
        chk_state("ovf", 12'h307, 4'd8, 1'b1, 1'b1, 1'b0);
        step(OP_RET, 12'h000, 8'h00, 1'b0, 1'b0);
        step(OP_JMP, 12'h555, 8'h00, 1'b0, 1'b1);
        step(OP_JMP, 12'h555, 8'h00, 1'b0, 1'b0);
        chk_state("ovf_frozen", 12'h307, 4'd8, 1'b1, 1'b1, 1'b0);

        // Underflow from an empty stack
        do_reset();
        chk_state("rst_clr_halt", 12'h000, 4'd0, 1'b0, 1'b0, 1'b0);
        step(OP_RET, 12'h000, 8'h00, 1'b0, 1'b0);
        chk_state("unf", 12'h000, 4'd0, 1'b1, 1'b0, 1'b1);
        step(OP_INC, 12'h000, 8'h00, 1'b0, 1'b0);
        step(OP_CALL, 12'h080, 8'h00, 1'b0, 1'b0);
        chk_state("unf_frozen", 12'h000, 4'd0, 1'b1, 1'b0, 1'b1);

`ifdef PC_SEQ_IRQ_EN
        do_reset();
        check("isr_rst", 16'(in_isr), 16'h0);
        step(OP_JMP, 12'h040, 8'h00, 1'b0, 1'b0);
        irq = 1'b1;
        step(OP_CALL, 12'h200, 8'h00, 1'b0, 1'b0);
        chk_state("irq_entry", 12'h010, 4'd1, 1'b0, 1'b0, 1'b0);
        check("irq_in_isr", 16'(in_isr), 16'h1);
        step(OP_INC, 12'h000, 8'h00, 1'b0, 1'b0);
        chk_state("irq_nested_ignored", 12'h011, 4'd1, 1'b0, 1'b0, 1'b0);
        irq = 1'b0;
        step(OP_RETI, 12'h000, 8'h00, 1'b0, 1'b0);
        chk_state("reti", 12'h040, 4'd0, 1'b0, 1'b0, 1'b0);
        check("reti_in_isr", 16'(in_isr), 16'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
